// File: rtl/dot_accumulator.sv
// Pipelined signed dot product accumulated over beats until s_last_i; DOT_ACC_SAT_EN selects saturating accumulation.
// Latency: last beat accepted at edge N -> m_valid_o high after edge N+2.
// Backpressure: s_ready_o low from the last beat until the result handshake; the result holds while m_ready_i is low.
module dot_accumulator #(
    parameter int IN_SIZE_0 = 4,
    parameter int IN_SIZE_1 = 8,
    parameter int NUM_LANES = 8,
    parameter int ACC_W     = IN_SIZE_0 + IN_SIZE_1 + 16
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        s_valid_i,
    output logic                        s_ready_o,
    input  logic                        s_last_i,
    input  logic signed [IN_SIZE_0-1:0] in_0_i [0:NUM_LANES-1],
    input  logic signed [IN_SIZE_1-1:0] in_1_i [0:NUM_LANES-1],
    output logic                        m_valid_o,
    input  logic                        m_ready_i,
    output logic signed [ACC_W-1:0]     m_data_o,
    output logic                        m_ovf_o
);
    localparam int PROD_W = IN_SIZE_0 + IN_SIZE_1;
    localparam int SUM_W  = PROD_W + $clog2(NUM_LANES);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {ACC, DRAIN, HOLD} state_t;

    state_t state;
    logic   accept;

    logic                        s1_vld;
    logic                        s1_last;
    logic signed [IN_SIZE_0-1:0] s1_a [0:NUM_LANES-1];
    logic signed [IN_SIZE_1-1:0] s1_b [0:NUM_LANES-1];

    logic signed [PROD_W-1:0]    prod [0:NUM_LANES-1];
    logic signed [SUM_W-1:0]     tree;

    logic                        s2_vld;
    logic                        s2_last;
    logic signed [SUM_W-1:0]     s2_sum;

    logic signed [ACC_W-1:0]     acc;
    logic signed [ACC_W-1:0]     addend;
    logic signed [ACC_W-1:0]     sum_nxt;
    logic                        ovf_now;
    logic                        ovf;
    logic                        first;

    assign accept = s_valid_i && s_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld  <= 1'b0;
            s1_last <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_last <= s_last_i;
                s1_a    <= in_0_i;
                s1_b    <= in_1_i;
            end
        end
    end

    // Operands are widened to PROD_W before multiplying so the most negative pair stays exact.
    always_comb begin
        tree = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            prod[i] = PROD_W'(s1_a[i]) * PROD_W'(s1_b[i]);
            tree    = tree + SUM_W'(prod[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_vld  <= 1'b0;
            s2_last <= 1'b0;
            s2_sum  <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_last <= s1_last;
                s2_sum  <= tree;
            end
        end
    end

    assign addend  = ACC_W'(s2_sum);
    assign sum_nxt = acc + addend;
    assign ovf_now = (acc[ACC_W-1] == addend[ACC_W-1]) && (sum_nxt[ACC_W-1] != acc[ACC_W-1]);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc   <= '0;
            ovf   <= 1'b0;
            first <= 1'b1;
        end else if (s2_vld) begin
            first <= 1'b0;
            if (first) begin
                acc <= addend;
                ovf <= 1'b0;
            end else begin
                ovf <= ovf | ovf_now;
`ifdef DOT_ACC_SAT_EN
                if (ovf_now) acc <= addend[ACC_W-1] ? ACC_MIN : ACC_MAX;
                else         acc <= sum_nxt;
`else
                acc <= sum_nxt;
`endif
            end
        end else if (m_valid_o && m_ready_i) begin
            first <= 1'b1;
        end
    end

    // Pipeline is empty in HOLD, so a beat and a handshake never coincide.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ACC;
            s_ready_o <= 1'b1;
            m_valid_o <= 1'b0;
        end else begin
            case (state)
                ACC: if (accept && s_last_i) begin
                    state     <= DRAIN;
                    s_ready_o <= 1'b0;
                end
                DRAIN: if (s2_vld && s2_last) begin
                    state     <= HOLD;
                    m_valid_o <= 1'b1;
                end
                HOLD: if (m_ready_i) begin
                    state     <= ACC;
                    m_valid_o <= 1'b0;
                    s_ready_o <= 1'b1;
                end
                default: begin
                    state     <= ACC;
                    s_ready_o <= 1'b1;
                    m_valid_o <= 1'b0;
                end
            endcase
        end
    end

    assign m_data_o = acc;
    assign m_ovf_o  = ovf;
endmodule

// File: tb/tb_dot_accumulator.sv
// Four dot_accumulator configurations driven in lockstep against a scoreboard of expected results.
module tb_dot_accumulator;
`ifdef DOT_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, s_valid, s_last, m_ready;
    logic signed [3:0] a0 [0:7];
    logic signed [7:0] b0 [0:7];
    logic signed [3:0] a2 [0:0];
    logic signed [7:0] b2 [0:0];
    logic signed [7:0] a3 [0:2];
    logic signed [7:0] b3 [0:2];

    logic rdy0, rdy1, rdy2, rdy3, vld0, vld1, vld2, vld3, o0, o1, o2, o3;
    logic signed [27:0] d0;
    logic signed [15:0] d1;
    logic signed [27:0] d2;
    logic signed [31:0] d3;

    int total = 0;
    int bad   = 0;

    longint acc0, acc1, acc2, acc3;
    bit     ovf1;
    bit     first_m = 1'b1;
    longint qd0[$], qd1[$], qd2[$], qd3[$];
    bit     qo1[$];

    assign a2[0] = a0[0];
    assign b2[0] = b0[0];

    always #5 clk = ~clk;

    dot_accumulator u0 (.clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(rdy0), .s_last_i(s_last),
        .in_0_i(a0), .in_1_i(b0), .m_valid_o(vld0), .m_ready_i(m_ready), .m_data_o(d0), .m_ovf_o(o0));
    dot_accumulator #(.ACC_W(16)) u1 (.clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(rdy1),
        .s_last_i(s_last), .in_0_i(a0), .in_1_i(b0), .m_valid_o(vld1), .m_ready_i(m_ready),
        .m_data_o(d1), .m_ovf_o(o1));
    dot_accumulator #(.NUM_LANES(1)) u2 (.clk_i(clk), .rst_i(rst), .s_valid_i(s_valid), .s_ready_o(rdy2),
        .s_last_i(s_last), .in_0_i(a2), .in_1_i(b2), .m_valid_o(vld2), .m_ready_i(m_ready),
        .m_data_o(d2), .m_ovf_o(o2));
    dot_accumulator #(.IN_SIZE_0(8), .IN_SIZE_1(8), .NUM_LANES(3)) u3 (.clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_ready_o(rdy3), .s_last_i(s_last), .in_0_i(a3), .in_1_i(b3),
        .m_valid_o(vld3), .m_ready_i(m_ready), .m_data_o(d3), .m_ovf_o(o3));

    task automatic chk(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rand_wide();
        foreach (a3[i]) begin
            a3[i] = 8'($urandom);
            b3[i] = 8'($urandom);
        end
    endtask

    task automatic set_all(int x, int y);
        foreach (a0[i]) begin
            a0[i] = 4'(x);
            b0[i] = 8'(y);
        end
        rand_wide();
    endtask

    task automatic rand_ops();
        foreach (a0[i]) begin
            a0[i] = 4'($urandom);
            b0[i] = 8'($urandom);
        end
        rand_wide();
    endtask

    task automatic model_beat(bit last);
        longint s0 = 0;
        longint s3 = 0;
        longint s2, t;
        foreach (a0[i]) s0 += longint'(a0[i]) * longint'(b0[i]);
        foreach (a3[i]) s3 += longint'(a3[i]) * longint'(b3[i]);
        s2 = longint'(a0[0]) * longint'(b0[0]);
        if (first_m) begin
            acc0 = s0; acc1 = s0; acc2 = s2; acc3 = s3;
            ovf1 = 1'b0;
            first_m = 1'b0;
        end else begin
            acc0 += s0; acc2 += s2; acc3 += s3;
            t = acc1 + s0;
            if (t > 32767) begin
                ovf1 = 1'b1;
                acc1 = SAT ? 32767 : t - 65536;
            end else if (t < -32768) begin
                ovf1 = 1'b1;
                acc1 = SAT ? -32768 : t + 65536;
            end else begin
                acc1 = t;
            end
        end
        if (last) begin
            qd0.push_back(acc0); qd1.push_back(acc1); qd2.push_back(acc2); qd3.push_back(acc3);
            qo1.push_back(ovf1);
            first_m = 1'b1;
        end
    endtask

    task automatic send(bit last);
        int w = 0;
        s_valid = 1'b1;
        s_last  = last;
        while (rdy0 !== 1'b1 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        total++;
        assert (w < 50) else begin
            bad++;
            $error("FAIL send: observed s_ready_o low for %0d cycles, expected accept", w);
        end
        if (w < 50) begin
            @(posedge clk);
            model_beat(last);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic collect(string tag);
        int w = 0;
        while (vld0 !== 1'b1 && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        total++;
        assert (w < 20 && qd0.size() > 0) else begin
            bad++;
            $error("FAIL %s.wait: observed m_valid_o=%b queued=%0d, expected a result", tag, vld0, qd0.size());
        end
        if (w < 20 && qd0.size() > 0) begin
            chk({tag, ".d0"}, d0, qd0.pop_front());
            chk({tag, ".d1"}, d1, qd1.pop_front());
            chk({tag, ".o1"}, o1, qo1.pop_front());
            chk({tag, ".d2"}, d2, qd2.pop_front());
            chk({tag, ".d3"}, d3, qd3.pop_front());
            chk({tag, ".o0"}, o0, 0);
            chk({tag, ".o2"}, o2, 0);
            chk({tag, ".o3"}, o3, 0);
            chk({tag, ".vld123"}, {vld1, vld2, vld3}, 3'b111);
            m_ready = 1'b1;
            @(posedge clk);
            #1;
            m_ready = 1'b0;
            chk({tag, ".vld_after"}, vld0, 0);
            chk({tag, ".rdy_after"}, rdy0, 1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        set_all(0, 0);
        idle(3);
        rst = 1'b0;
        chk("reset.rdy", rdy0, 1);
        chk("reset.vld", vld0, 0);
        chk("reset.data", d0, 0);
        chk("reset.ovf", o0, 0);

        // Single-beat extreme with latency check.
        set_all(-8, -128);
        send(1'b1);
        chk("lat.n0", vld0, 0);
        idle(1);
        chk("lat.n1", vld0, 0);
        idle(1);
        chk("lat.n2", vld0, 1);
        chk("extreme.d0", d0, 8192);
        collect("extreme");

        // Multi-beat with bubbles.
        set_all(1, 2);  send(1'b0); idle(2);
        set_all(1, -3); send(1'b0); idle(1);
        set_all(1, 5);  send(1'b1);
        chk("bubbles.model", acc0, 32);
        collect("bubbles");

        // Backpressure in HOLD with a beat offered meanwhile.
        set_all(1, 3);
        send(1'b1);
        idle(2);
        chk("bp.vld", vld0, 1);
        set_all(1, 1);
        s_valid = 1'b1;
        s_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp.data", d0, 24);
            chk("bp.rdy", rdy0, 0);
            idle(1);
        end
        collect("bp");
        send(1'b1);
        collect("bp_next");

        // Overflow on the 16-bit instance, then a clean vector.
        set_all(-8, -128);
        repeat (3) send(1'b0);
        send(1'b1);
        chk("ovf.o1_exp", qo1[0], 1);
        collect("ovf");
        set_all(0, 0);
        a0[0] = 4'sd1;
        b0[0] = 8'sd5;
        send(1'b1);
        collect("ovf_clear");

        // Reset in the middle of a vector.
        set_all(1, 2);
        send(1'b0);
        send(1'b0);
        idle(2);
        chk("rstmid.partial", d0, 32);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        first_m = 1'b1;
        chk("rstmid.data", d0, 0);
        chk("rstmid.rdy", rdy0, 1);
        idle(5);
        chk("rstmid.vld", vld0, 0);
        set_all(1, 2);
        send(1'b1);
        collect("rstmid_next");

        // Random sweep across all configurations.
        for (int v = 0; v < 10; v++) begin
            int nb = $urandom_range(1, 4);
            for (int b = 0; b < nb; b++) begin
                rand_ops();
                send(b == nb - 1);
                idle($urandom_range(0, 2));
            end
            collect("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
